// File: rtl/qtable_policy_reader_if.sv
// Bus bundle for qtable_policy_reader: state request, Q-table read port, policy response.
// Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds
// valid and payload stable until it happens, and the receiver may drive ready at any time.
interface qtable_policy_reader_if #(
    parameter int STATE_WIDTH  = 6,
    parameter int ACTION_WIDTH = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8
);
    logic                    i_req_valid;
    logic                    o_req_ready;
    logic [STATE_WIDTH-1:0]  i_req_state;
    logic [ADDR_WIDTH-1:0]   o_q_addr;
    logic                    o_q_rd;
    logic [DATA_WIDTH-1:0]   i_q_data;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [STATE_WIDTH-1:0]  o_rsp_state;
    logic [ACTION_WIDTH-1:0] o_rsp_action;
    logic [DATA_WIDTH-1:0]   o_rsp_qmax;
    logic [1:0]              dbg_state;

    modport slave (
        input  i_req_valid, i_req_state, i_q_data, i_rsp_ready,
        output o_req_ready, o_q_addr, o_q_rd, o_rsp_valid, o_rsp_state,
               o_rsp_action, o_rsp_qmax, dbg_state
    );

    modport master (
        output i_req_valid, i_req_state, i_q_data, i_rsp_ready,
        input  o_req_ready, o_q_addr, o_q_rd, o_rsp_valid, o_rsp_state,
               o_rsp_action, o_rsp_qmax, dbg_state
    );
endinterface

// File: rtl/qtable_policy_reader.sv
// Greedy policy reader: scans all Q values of a state and returns argmax action and max Q.
// Optional epsilon-greedy exploration is enabled with the macro QPOLICY_EPSILON_GREEDY_EN.
module qtable_policy_reader #(
    parameter int STATE_WIDTH  = 6,
    parameter int ACTION_WIDTH = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
`ifdef QPOLICY_EPSILON_GREEDY_EN
    input  logic [7:0] i_epsilon,
    output logic       o_rsp_explore,
`endif
    qtable_policy_reader_if.slave bus
);
    localparam int NUM_ACTIONS = 2 ** ACTION_WIDTH;
    localparam logic [ACTION_WIDTH-1:0] K_LAST = ACTION_WIDTH'(NUM_ACTIONS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

    state_t                  fsm;
    logic [STATE_WIDTH-1:0]  st_q;
    logic [ACTION_WIDTH-1:0] k;
    logic [ACTION_WIDTH-1:0] k_inc;
    logic [ACTION_WIDTH-1:0] a_d;
    logic                    rd_d;
    logic [DATA_WIDTH-1:0]   best_q;
    logic [ACTION_WIDTH-1:0] best_a;
    logic                    take;
    logic [DATA_WIDTH-1:0]   best_q_nx;
    logic [ACTION_WIDTH-1:0] best_a_nx;

    // rd_d/a_d track the read issued last cycle, whose data is on i_q_data now.
    always_comb begin
        k_inc     = k + ACTION_WIDTH'(1);
        take      = rd_d && ((a_d == '0) || (bus.i_q_data > best_q));
        best_q_nx = take ? bus.i_q_data : best_q;
        best_a_nx = take ? a_d : best_a;
    end

    assign bus.dbg_state = fsm;

`ifdef QPOLICY_EPSILON_GREEDY_EN
    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, free-running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lfsr <= 16'hACE1;
        else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm              <= IDLE;
            st_q             <= '0;
            k                <= '0;
            a_d              <= '0;
            rd_d             <= 1'b0;
            best_q           <= '0;
            best_a           <= '0;
            bus.o_req_ready  <= 1'b1;
            bus.o_q_rd       <= 1'b0;
            bus.o_q_addr     <= '0;
            bus.o_rsp_valid  <= 1'b0;
            bus.o_rsp_state  <= '0;
            bus.o_rsp_action <= '0;
            bus.o_rsp_qmax   <= '0;
`ifdef QPOLICY_EPSILON_GREEDY_EN
            o_rsp_explore    <= 1'b0;
`endif
        end else begin
            rd_d <= bus.o_q_rd;
            a_d  <= k;
            if (rd_d) begin
                best_q <= best_q_nx;
                best_a <= best_a_nx;
            end
            case (fsm)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        st_q            <= bus.i_req_state;
                        k               <= '0;
                        best_q          <= '0;
                        best_a          <= '0;
                        bus.o_req_ready <= 1'b0;
                        bus.o_q_rd      <= 1'b1;
                        bus.o_q_addr    <= ADDR_WIDTH'({bus.i_req_state, {ACTION_WIDTH{1'b0}}});
                        fsm             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k == K_LAST) begin
                        bus.o_q_rd <= 1'b0;
                        fsm        <= DRAIN;
                    end else begin
                        k            <= k_inc;
                        bus.o_q_addr <= ADDR_WIDTH'({st_q, k_inc});
                    end
                end
                DRAIN: begin
                    // Last action's data arrives now, so the response uses the bypassed best.
                    bus.o_rsp_valid  <= 1'b1;
                    bus.o_rsp_state  <= st_q;
                    bus.o_rsp_qmax   <= best_q_nx;
                    bus.o_rsp_action <= best_a_nx;
`ifdef QPOLICY_EPSILON_GREEDY_EN
                    o_rsp_explore    <= 1'b0;
                    if (lfsr[7:0] < i_epsilon) begin
                        bus.o_rsp_action <= lfsr[8 +: ACTION_WIDTH];
                        o_rsp_explore    <= 1'b1;
                    end
`endif
                    fsm <= RESP;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        bus.o_rsp_valid <= 1'b0;
                        bus.o_req_ready <= 1'b1;
                        fsm             <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qtable_policy_reader.sv
// Bench for qtable_policy_reader: directed vector table, reset/backpressure corners, random requests.
module tb_qtable_policy_reader;
    localparam int SW = 6;
    localparam int AW = 2;
    localparam int ADW = 8;
    localparam int DW = 8;
    localparam int NA = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qtable_policy_reader_if #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) bus ();

    logic [7:0] mem [256];
    logic [7:0] eps;
    logic       explore;
    int         n_explore = 0;

`ifdef QPOLICY_EPSILON_GREEDY_EN
    qtable_policy_reader #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_epsilon(eps), .o_rsp_explore(explore), .bus(bus));
`else
    qtable_policy_reader #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    assign explore = 1'b0;
`endif

    // Q-table BRAM model with one cycle of read latency.
    always @(posedge clk) if (bus.o_q_rd) bus.i_q_data <= mem[bus.o_q_addr];

    int n_pass = 0;
    int n_tot = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Argmax with strict greater-than so the lowest action wins ties. Returns {action, qmax}.
    function automatic logic [9:0] model(input int s);
        int best;
        int ba;
        best = mem[s * NA];
        ba = 0;
        for (int a = 1; a < NA; a++)
            if (int'(mem[s * NA + a]) > best) begin
                best = mem[s * NA + a];
                ba = a;
            end
        return {2'(ba), 8'(best)};
    endfunction

    typedef struct {
        logic [5:0]  st;
        logic [7:0]  q [4];
        logic [1:0]  exp_a;
        logic [7:0]  exp_q;
        int          hold;
    } vec_t;

    function automatic vec_t mk(input int st, input int q0, input int q1, input int q2, input int q3,
                                input int ea, input int eq, input int hold);
        vec_t v;
        v.st = 6'(st);
        v.q[0] = 8'(q0); v.q[1] = 8'(q1); v.q[2] = 8'(q2); v.q[3] = 8'(q3);
        v.exp_a = 2'(ea); v.exp_q = 8'(eq); v.hold = hold;
        return v;
    endfunction

    // One full transaction starting at a negedge with the reader idle; checks cycle-exact timing.
    task automatic do_req(input logic [5:0] s, input int hold, input logic [1:0] ea, input logic [7:0] eq);
        logic [15:0] e;
        exp_q.push_back({s, ea, eq});
        chk("req_ready_idle", bus.o_req_ready, 1);
        bus.i_req_valid = 1'b1;
        bus.i_req_state = s;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        bus.i_req_state = 6'($urandom);
        for (int a = 0; a < NA; a++) begin
            chk("q_rd_issue", bus.o_q_rd, 1);
            chk("q_addr", bus.o_q_addr, s * NA + a);
            chk("req_ready_busy", bus.o_req_ready, 0);
            @(negedge clk);
        end
        chk("q_rd_drain", bus.o_q_rd, 0);
        chk("rsp_valid_drain", bus.o_rsp_valid, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        if (explore) n_explore++;
        if (eps == 8'd0) chk("explore_eps0", explore, 0);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", bus.o_rsp_valid, 1);
            chk("rsp_state", bus.o_rsp_state, e[15:10]);
            chk("rsp_qmax", bus.o_rsp_qmax, e[7:0]);
            if (!explore) chk("rsp_action", bus.o_rsp_action, e[9:8]);
            chk("q_rd_resp", bus.o_q_rd, 0);
            chk("req_ready_resp", bus.o_req_ready, 0);
            if (h < hold) @(negedge clk);
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", bus.o_rsp_valid, 0);
        chk("req_ready_after_hs", bus.o_req_ready, 1);
    endtask

    task automatic load(input vec_t v);
        for (int a = 0; a < NA; a++) mem[v.st * NA + a] = v.q[a];
    endtask

    vec_t vecs [7];

    initial begin
        logic [9:0] m;
        logic [5:0] s;
        vecs[0] = mk(5,  3,   9,   9,   2,   1, 9,   0);
        vecs[1] = mk(0,  0,   0,   0,   0,   0, 0,   2);
        vecs[2] = mk(63, 1,   2,   3,   255, 3, 255, 1);
        vecs[3] = mk(17, 200, 50,  100, 199, 0, 200, 10);
        vecs[4] = mk(42, 7,   7,   7,   7,   0, 7,   0);
        vecs[5] = mk(33, 0,   0,   0,   1,   3, 1,   0);
        vecs[6] = mk(9,  128, 127, 255, 254, 2, 255, 3);

        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        bus.i_req_valid = 1'b0;
        bus.i_req_state = '0;
        bus.i_rsp_ready = 1'b0;
        bus.i_q_data = '0;
        eps = 8'd0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.o_req_ready, 1);
        chk("rst_rsp_valid", bus.o_rsp_valid, 0);
        chk("rst_q_rd", bus.o_q_rd, 0);
        chk("rst_q_addr", bus.o_q_addr, 0);
        chk("rst_rsp_action", bus.o_rsp_action, 0);
        chk("rst_rsp_qmax", bus.o_rsp_qmax, 0);
        chk("rst_rsp_state", bus.o_rsp_state, 0);
        chk("rst_dbg_state", bus.dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i]);
            do_req(vecs[i].st, vecs[i].hold, vecs[i].exp_a, vecs[i].exp_q);
        end

        // Reset pulse in the second read cycle abandons the transaction.
        load(mk(7, 4, 90, 12, 90, 1, 90, 0));
        bus.i_req_valid = 1'b1;
        bus.i_req_state = 6'd7;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.o_rsp_valid, 0);
        chk("midrst_q_rd", bus.o_q_rd, 0);
        chk("midrst_req_ready", bus.o_req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("postrst_rsp_valid", bus.o_rsp_valid, 0);
            chk("postrst_req_ready", bus.o_req_ready, 1);
        end
        do_req(6'd7, 0, 2'd1, 8'd90);

        for (int i = 0; i < 60; i++) begin
            s = 6'($urandom_range(0, 63));
            for (int a = 0; a < NA; a++)
                mem[s * NA + a] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            m = model(s);
            do_req(s, $urandom_range(0, 3), m[9:8], m[7:0]);
        end

`ifdef QPOLICY_EPSILON_GREEDY_EN
        eps = 8'd255;
        n_explore = 0;
        for (int i = 0; i < 40; i++) begin
            s = 6'($urandom_range(0, 63));
            for (int a = 0; a < NA; a++) mem[s * NA + a] = 8'($urandom_range(0, 255));
            m = model(s);
            do_req(s, 0, m[9:8], m[7:0]);
        end
        chk("explore_rate_high", (n_explore >= 36) ? 1 : 0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
